ucode_sequencer: RTL and testbench

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

---
 rtl/ucode_sequencer.sv | 157 +++++++++++++++
 tb/tb_ucode_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: IDLE/ADDR/EXEC, one micro-step per two clocks, registered control word.
// Each executed word is visible one clock after its EXEC state. run/step requests are dropped while busy.
module ucode_sequencer #(
  parameter logic [31:0] DEFAULT_CW   = 32'h0000_0000,
  parameter int          STEP_RST_BIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] host_cw,
  input  logic        host_cw_valid,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        stop_req,
  input  logic [7:0]  opcode,
  input  logic [3:0]  flags,
  input  logic        brk,
  input  logic        hlt_n,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] control_word,
  output logic        cw_strobe,
  output logic        busy,
  output logic        done,
  output logic [2:0]  stat,
  output logic [3:0]  step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    EXEC = 2'd2
  } state_t;

  localparam logic [2:0] STAT_NONE = 3'd0;
  localparam logic [2:0] STAT_BRK  = 3'd1;
  localparam logic [2:0] STAT_HLT  = 3'd2;
  localparam logic [2:0] STAT_STOP = 3'd3;
  localparam logic [2:0] STAT_OVF  = 3'd4;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] cw_q, cw_d;
  logic        strobe_q, strobe_d;
  logic        ret_q, ret_d;
  logic        done_q, done_d;
  logic [2:0]  stat_q, stat_d;
  logic        stop_q, stop_d;
  logic        single_q, single_d;

  logic        boundary;
  logic        overflow;
  logic        stop_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= 4'd0;
      cw_q     <= DEFAULT_CW;
      strobe_q <= 1'b0;
      ret_q    <= 1'b0;
      done_q   <= 1'b0;
      stat_q   <= STAT_NONE;
      stop_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cw_q     <= cw_d;
      strobe_q <= strobe_d;
      ret_q    <= ret_d;
      done_q   <= done_d;
      stat_q   <= stat_d;
      stop_q   <= stop_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cw_d      = cw_q;
    strobe_d  = 1'b0;
    ret_d     = 1'b0;
    done_d    = ret_q;
    stat_d    = stat_q;
    stop_d    = stop_q;
    single_d  = single_q;
    boundary  = rom_data[STEP_RST_BIT];
    overflow  = !boundary && (step_q == 4'd15);
    stop_pend = stop_q || stop_req;

    case (state_q)
      IDLE: begin
        cw_d   = host_cw_valid ? host_cw : DEFAULT_CW;
        stop_d = 1'b0;
        // step_req has priority over a simultaneous run_req
        if (step_req) begin
          state_d  = ADDR;
          single_d = 1'b1;
          stat_d   = STAT_NONE;
        end else if (run_req) begin
          state_d  = ADDR;
          single_d = 1'b0;
          stat_d   = STAT_NONE;
        end
      end

      ADDR: begin
        cw_d    = DEFAULT_CW;
        state_d = EXEC;
        if (stop_req) begin
          stop_d = 1'b1;
        end
      end

      EXEC: begin
        cw_d     = rom_data;
        strobe_d = 1'b1;
        stop_d   = 1'b0;
        step_d   = boundary ? 4'd0 : step_q + 4'd1;
        // stop causes leave step where it landed so a later run resumes mid-instruction
        if (brk) begin
          state_d = IDLE;
          stat_d  = STAT_BRK;
        end else if (!hlt_n) begin
          state_d = IDLE;
          stat_d  = STAT_HLT;
        end else if (stop_pend) begin
          state_d = IDLE;
          stat_d  = STAT_STOP;
        end else if (overflow) begin
          state_d = IDLE;
          stat_d  = STAT_OVF;
        end else if (single_q && boundary) begin
          state_d = IDLE;
          stat_d  = STAT_NONE;
        end else begin
          state_d = ADDR;
        end
        ret_d = (state_d == IDLE);
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr     = (state_q == ADDR) ? {opcode, flags, step_q} : 16'h0000;
  assign control_word = cw_q;
  assign cw_strobe    = strobe_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign stat         = stat_q;
  assign step         = step_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: expected strobes queued with their cycle, popped by a monitor.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] host_cw;
  logic        host_cw_valid;
  logic        run_req, step_req, stop_req;
  logic [7:0]  opcode;
  logic [3:0]  flags;
  logic        brk, hlt_n;
  logic [15:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] control_word;
  logic        cw_strobe, busy, done;
  logic [2:0]  stat;
  logic [3:0]  step;

  typedef struct {
    logic [31:0] cw;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rom_mem [logic [15:0]];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          t0;

  ucode_sequencer dut (
    .clk(clk), .rst(rst), .host_cw(host_cw), .host_cw_valid(host_cw_valid),
    .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .opcode(opcode), .flags(flags), .brk(brk), .hlt_n(hlt_n),
    .rom_addr(rom_addr), .rom_data(rom_data), .control_word(control_word),
    .cw_strobe(cw_strobe), .busy(busy), .done(done), .stat(stat), .step(step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM: data one cycle after the address
  always @(posedge clk) rom_data <= rom_mem.exists(rom_addr) ? rom_mem[rom_addr] : 32'h0;

  always @(negedge clk) begin
    if (!rst && cw_strobe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got cw=%h at cycle %0d, expected no strobe", control_word, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (control_word !== e.cw || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe: got cw=%h at cycle %0d, expected cw=%h at cycle %0d",
                   control_word, cyc, e.cw, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] cw, input int at);
    exp_t e;
    e.cw  = cw;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done within %0d cycles, expected done at cycle %0d", name, bound, exp_cyc);
    end else if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle: got done at cycle %0d expected %0d", name, cyc, exp_cyc);
    end
    tick();
    chk({name, "_done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; host_cw = 32'h0; host_cw_valid = 1'b0;
    run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    opcode = 8'h00; flags = 4'h0; brk = 1'b0; hlt_n = 1'b1;

    rom_mem[16'h0500] = 32'h0000_000A;
    rom_mem[16'h0501] = 32'h0000_000B;
    rom_mem[16'h0502] = 32'h8000_000C;
    rom_mem[16'h0600] = 32'h0000_0011;
    rom_mem[16'h0601] = 32'h0000_0012;
    rom_mem[16'h0602] = 32'h0000_0013;
    rom_mem[16'h0603] = 32'h8000_0014;
    for (int i = 0; i < 16; i++) rom_mem[16'h0700 + 16'(i)] = 32'h100 + 32'(i);

    tick(); tick();
    chk("rst_cw", control_word, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_strobe", {31'h0, cw_strobe}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_stat", {29'h0, stat}, 32'h0);
    chk("rst_step", {28'h0, step}, 32'h0);
    chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0);
    rst = 1'b0;
    tick();

    // host control word passes through one cycle later while idle
    host_cw_valid = 1'b1; host_cw = 32'h1234_5678;
    tick();
    chk("host_cw", control_word, 32'h1234_5678);
    chk("host_busy", {31'h0, busy}, 32'h0);
    chk("host_strobe", {31'h0, cw_strobe}, 32'h0);
    host_cw_valid = 1'b0;
    tick();
    chk("host_default", control_word, 32'h0);

    // single step through a three-step instruction
    opcode = 8'h05; flags = 4'h0;
    step_req = 1'b1;
    tick(); t0 = cyc; step_req = 1'b0;
    push(32'h0000_000A, t0 + 2); push(32'h0000_000B, t0 + 4); push(32'h8000_000C, t0 + 6);
    chk("step_busy", {31'h0, busy}, 32'h1);
    wait_done("step", t0 + 7, 20);
    chk("step_stat", {29'h0, stat}, 32'h0);
    chk("step_step", {28'h0, step}, 32'h0);

    // run stopped by brk in the second EXEC
    opcode = 8'h06;
    run_req = 1'b1;
    tick(); t0 = cyc; run_req = 1'b0;
    push(32'h0000_0011, t0 + 2); push(32'h0000_0012, t0 + 4);
    tick(); tick(); tick();
    brk = 1'b1;
    tick();
    brk = 1'b0;
    wait_done("brk", t0 + 5, 10);
    chk("brk_stat", {29'h0, stat}, 32'h1);
    chk("brk_step", {28'h0, step}, 32'h2);

    // resume at step 2, stop_req latched during ADDR of step 3
    run_req = 1'b1;
    tick(); t0 = cyc; run_req = 1'b0;
    push(32'h0000_0013, t0 + 2); push(32'h8000_0014, t0 + 4);
    tick(); tick();
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_done("stop", t0 + 5, 10);
    chk("stop_stat", {29'h0, stat}, 32'h3);
    chk("stop_step", {28'h0, step}, 32'h0);

    // hlt_n outranks a pending stop_req
    run_req = 1'b1;
    tick(); t0 = cyc; run_req = 1'b0;
    push(32'h0000_0011, t0 + 2);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0; hlt_n = 1'b0;
    tick();
    hlt_n = 1'b1;
    wait_done("hlt", t0 + 3, 10);
    chk("hlt_stat", {29'h0, stat}, 32'h2);
    chk("hlt_step", {28'h0, step}, 32'h1);

    // idle stop_req discarded; step beats run; run while busy ignored
    opcode = 8'h05;
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0; step_req = 1'b1; run_req = 1'b1;
    tick(); t0 = cyc; step_req = 1'b0; run_req = 1'b0;
    push(32'h0000_000B, t0 + 2); push(32'h8000_000C, t0 + 4);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    wait_done("prio", t0 + 5, 20);
    chk("prio_stat", {29'h0, stat}, 32'h0);
    chk("prio_step", {28'h0, step}, 32'h0);

    // no boundary bit: 16 strobes then overflow
    opcode = 8'h07;
    run_req = 1'b1;
    tick(); t0 = cyc; run_req = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), t0 + 2 + 2 * i);
    wait_done("ovf", t0 + 33, 60);
    chk("ovf_stat", {29'h0, stat}, 32'h4);
    chk("ovf_step", {28'h0, step}, 32'h0);

    // asynchronous reset while a strobe is showing and step is mid-instruction
    opcode = 8'h05;
    step_req = 1'b1;
    tick(); t0 = cyc; step_req = 1'b0;
    tick(); tick();
    chk("pre_rst_cw", control_word, 32'h0000_000A);
    chk("pre_rst_strobe", {31'h0, cw_strobe}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_cw", control_word, 32'h0);
    chk("async_strobe", {31'h0, cw_strobe}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_step", {28'h0, step}, 32'h0);
    tick();
    rst = 1'b0; step_req = 1'b1;
    tick(); t0 = cyc; step_req = 1'b0;
    push(32'h0000_000A, t0 + 2); push(32'h0000_000B, t0 + 4); push(32'h8000_000C, t0 + 6);
    wait_done("post_rst", t0 + 7, 20);
    chk("post_rst_stat", {29'h0, stat}, 32'h0);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
